sda_host_kernel_driver: RTL and testbench
=========================================

SDA_HOST_KERNEL_DRIVER -- requirements
Module: sda_host_kernel_driver

Interface
REQ-001 The block SHALL have parameter AXI_SLAVE_ADDR_WIDTH, default 6, which sets the width of the control-bus address.
REQ-002 The block SHALL have parameter POLL_GAP, default 8, which sets the idle cycles between status reads (1..255).
REQ-003 The block SHALL have parameter TIMEOUT, default 65535, which sets the maximum poll-phase cycles before abort.
REQ-004 The block SHALL have these ports:
  ap_clk  in  1  sole clock
  ap_rst_n  in  1  reset, asynchronous and active-low
  cmd_valid / cmd_ready  in/out  1/1  launch handshake
  cmd_param_base  in  64  parameter buffer base
  cmd_print_base  in  64  print buffer base
  rsp_valid / rsp_ready  out/in  1/1  completion handshake
  rsp_status  out  2  00 OK, 01 SLVERR, 10 TIMEOUT
  rsp_polls  out  16  status reads issued, saturating
  m_axi_control_AW*  AWADDR[AXI_SLAVE_ADDR_WIDTH] out, AWVALID out, AWREADY in
  m_axi_control_W*  WDATA[32] out, WSTRB[4] out, WVALID out, WREADY in
  m_axi_control_B*  BRESP[2] in, BVALID in, BREADY out
  m_axi_control_AR*  ARADDR[AXI_SLAVE_ADDR_WIDTH] out, ARVALID out, ARREADY in
  m_axi_control_R*  RDATA[32] in, RRESP[2] in, RVALID in, RREADY out
  busy  out  1  high from cmd accept until rsp handshake

Function
REQ-005 cmd_ready SHALL be high only in state IDLE; on cmd_valid&&cmd_ready the block SHALL register both bases, clear the poll count and enter WRITE.
REQ-006 WRITE SHALL issue, in order: 0x10 = param[31:0], 0x14 = param[63:32], 0x18 = print[31:0], 0x1C = print[63:32], 0x00 = 32'h1 (ap_start). WSTRB SHALL be 4'hF for all writes.
REQ-007 Each write SHALL assert AWVALID and WVALID in the same cycle. Each SHALL hold its address/data stable until its own READY is sampled high. AWREADY and WREADY MAY arrive in any order or in the same cycle.
REQ-008 After both AW and W are accepted, the block SHALL enter WRESP with BREADY=1. BREADY SHALL be 0 in all other states.
REQ-009 BVALID with BRESP==00 SHALL advance to the next write, or after the 0x00 write to POLL_WAIT. Any nonzero BRESP SHALL go to RESP with status 01 without issuing further writes.
REQ-010 POLL_WAIT SHALL count POLL_GAP cycles, then enter RD_ADDR with ARVALID=1 and ARADDR=0, held until ARREADY.
REQ-011 RD_DATA SHALL assert RREADY=1 and increment rsp_polls on RVALID, saturating at 16'hFFFF.
REQ-012 On RVALID, RRESP!=00 SHALL give status 01. Otherwise RDATA[1] (ap_done)=1 SHALL give status 00. Otherwise the block SHALL return to POLL_WAIT.
REQ-013 A poll-phase cycle counter SHALL start at 0 on entry to POLL_WAIT after the start write and SHALL increment every cycle until RESP.
REQ-014 When the counter reaches TIMEOUT while in POLL_WAIT, the block SHALL go to RESP with status 10.
REQ-015 When the counter reaches TIMEOUT in RD_ADDR or RD_DATA, the block SHALL complete the outstanding read and then take status 10, unless that read returns done or an error, which takes priority.
REQ-016 RESP SHALL hold rsp_valid=1 with status and poll count stable until rsp_ready, then return to IDLE. rsp_valid and cmd_ready SHALL never be high in the same cycle.
REQ-017 All AXI outputs SHALL be registered. No VALID SHALL depend combinationally on any READY.

Reset
REQ-018 While ap_rst_n=0, the block SHALL immediately force: state IDLE, cmd_ready=0, all VALID/READY outputs 0, rsp_valid=0, busy=0, rsp_status=00, rsp_polls=0, addresses/data 0, counters 0.
REQ-019 cmd_ready SHALL rise on the first clock edge after ap_rst_n deasserts.
REQ-020 Reset mid-transaction SHALL abandon the sequence with no replay. Outstanding slave responses SHALL be ignored.

Verification
REQ-021 Nominal run: param=0x0000_0001_8000_0000, print=0x0000_0002_0000_0040, slave sets done on the 3rd status read.
  -> Five writes in order with the listed data.
  -> rsp_status=00, rsp_polls=3.
REQ-022 Handshake skew: AWREADY 3 cycles before WREADY on one write, WREADY first on another, both same-cycle on a third.
  -> Each write is issued exactly once.
  -> No VALID drops before its READY.
REQ-023 BRESP=10 on the 0x14 write.
  -> No writes to 0x18, 0x1C or 0x00.
  -> rsp_status=01, rsp_polls=0.
REQ-024 TIMEOUT=100, POLL_GAP=8, done never set.
  -> rsp_status=10 at most one read latency past 100 poll-phase cycles.
  -> rsp_polls matches the reads issued.
REQ-025 rsp_ready held low 20 cycles.
  -> rsp_valid and outputs stay stable.
  -> cmd_ready=0 until the rsp handshake completes.
REQ-026 ap_rst_n pulsed low during RD_DATA.
  -> All outputs at reset values that cycle.
  -> A new command afterwards completes normally.

Source files
------------

// File: rtl/sda_host_kernel_driver.sv
// rtl/sda_host_kernel_driver.sv - launches an HLS-style kernel over its control bus and polls it to completion
//
// Writes the parameter and print buffer bases into the kernel's control
// registers, sets ap_start, then reads the control register every POLL_GAP
// cycles until ap_done, a slave error, or the poll-phase timeout.
//
// Ports:
//   ap_clk, ap_rst_n   clock; asynchronous active-low reset
//   cmd_valid/ready    launch handshake, carrying cmd_param_base / cmd_print_base
//   rsp_valid/ready    completion handshake
//   rsp_status         00 ok, 01 slave error, 10 timeout
//   rsp_polls          status reads issued for this command (saturating)
//   m_axi_control_*    control-bus master: AW/W/B program the kernel, AR/R poll it
//   busy               high from command accept until the response handshake
module sda_host_kernel_driver #(
  parameter int AXI_SLAVE_ADDR_WIDTH = 6,
  parameter int POLL_GAP             = 8,
  parameter int TIMEOUT              = 65535
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [63:0]                     cmd_param_base,
  input  logic [63:0]                     cmd_print_base,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [1:0]                      rsp_status,
  output logic [15:0]                     rsp_polls,
  output logic [AXI_SLAVE_ADDR_WIDTH-1:0] m_axi_control_AWADDR,
  output logic                            m_axi_control_AWVALID,
  input  logic                            m_axi_control_AWREADY,
  output logic [31:0]                     m_axi_control_WDATA,
  output logic [3:0]                      m_axi_control_WSTRB,
  output logic                            m_axi_control_WVALID,
  input  logic                            m_axi_control_WREADY,
  input  logic [1:0]                      m_axi_control_BRESP,
  input  logic                            m_axi_control_BVALID,
  output logic                            m_axi_control_BREADY,
  output logic [AXI_SLAVE_ADDR_WIDTH-1:0] m_axi_control_ARADDR,
  output logic                            m_axi_control_ARVALID,
  input  logic                            m_axi_control_ARREADY,
  input  logic [31:0]                     m_axi_control_RDATA,
  input  logic [1:0]                      m_axi_control_RRESP,
  input  logic                            m_axi_control_RVALID,
  output logic                            m_axi_control_RREADY,
  output logic                            busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_POLL_WAIT, S_RD_ADDR, S_RD_DATA, S_RESP
  } state_t;

  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [7:0]  GAP_LAST  = 8'(POLL_GAP - 1);

  state_t      state;
  logic [63:0] param_q;
  logic [63:0] print_q;
  logic [2:0]  wr_idx;
  logic [7:0]  gap_cnt;
  logic [31:0] poll_cyc;
  logic        timed_out;
  logic        in_poll;
  logic        rdata_unused;

  // poll_cyc saturates at TIMEOUT, so the equality stays true once reached
  assign timed_out    = (poll_cyc == TIMEOUT_C);
  assign in_poll      = (state == S_POLL_WAIT) || (state == S_RD_ADDR) || (state == S_RD_DATA);
  assign rdata_unused = ^{m_axi_control_RDATA[31:2], m_axi_control_RDATA[0]};

  // Setup write sequence: buffer bases low/high words, then ap_start last
  function automatic logic [AXI_SLAVE_ADDR_WIDTH-1:0] wr_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    wr_addr = AXI_SLAVE_ADDR_WIDTH'(8'h10);
      3'd1:    wr_addr = AXI_SLAVE_ADDR_WIDTH'(8'h14);
      3'd2:    wr_addr = AXI_SLAVE_ADDR_WIDTH'(8'h18);
      3'd3:    wr_addr = AXI_SLAVE_ADDR_WIDTH'(8'h1C);
      default: wr_addr = '0;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0] idx, input logic [63:0] prm,
                                          input logic [63:0] prt);
    case (idx)
      3'd0:    wr_data = prm[31:0];
      3'd1:    wr_data = prm[63:32];
      3'd2:    wr_data = prt[31:0];
      3'd3:    wr_data = prt[63:32];
      default: wr_data = 32'h1;
    endcase
  endfunction

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state                 <= S_IDLE;
      param_q               <= '0;
      print_q               <= '0;
      wr_idx                <= '0;
      gap_cnt               <= '0;
      poll_cyc              <= '0;
      cmd_ready             <= 1'b0;
      rsp_valid             <= 1'b0;
      rsp_status            <= 2'b00;
      rsp_polls             <= '0;
      busy                  <= 1'b0;
      m_axi_control_AWADDR  <= '0;
      m_axi_control_AWVALID <= 1'b0;
      m_axi_control_WDATA   <= '0;
      m_axi_control_WSTRB   <= '0;
      m_axi_control_WVALID  <= 1'b0;
      m_axi_control_BREADY  <= 1'b0;
      m_axi_control_ARADDR  <= '0;
      m_axi_control_ARVALID <= 1'b0;
      m_axi_control_RREADY  <= 1'b0;
    end else begin
      // Poll-phase clock keeps running through reads, freezes once in RESP
      if (in_poll && !timed_out) poll_cyc <= poll_cyc + 32'd1;

      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready             <= 1'b0;
            busy                  <= 1'b1;
            param_q               <= cmd_param_base;
            print_q               <= cmd_print_base;
            rsp_polls             <= '0;
            rsp_status            <= 2'b00;
            wr_idx                <= 3'd0;
            m_axi_control_AWADDR  <= wr_addr(3'd0);
            m_axi_control_WDATA   <= wr_data(3'd0, cmd_param_base, cmd_print_base);
            m_axi_control_WSTRB   <= 4'hF;
            m_axi_control_AWVALID <= 1'b1;
            m_axi_control_WVALID  <= 1'b1;
            state                 <= S_WRITE;
          end
        end

        S_WRITE: begin
          // AW and W retire independently; move on once both have gone
          if (m_axi_control_AWREADY) m_axi_control_AWVALID <= 1'b0;
          if (m_axi_control_WREADY)  m_axi_control_WVALID  <= 1'b0;
          if ((!m_axi_control_AWVALID || m_axi_control_AWREADY) &&
              (!m_axi_control_WVALID  || m_axi_control_WREADY)) begin
            m_axi_control_BREADY <= 1'b1;
            state                <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (m_axi_control_BVALID) begin
            m_axi_control_BREADY <= 1'b0;
            if (m_axi_control_BRESP != 2'b00) begin
              rsp_status <= 2'b01;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else if (wr_idx == 3'd4) begin
              gap_cnt  <= '0;
              poll_cyc <= '0;
              state    <= S_POLL_WAIT;
            end else begin
              wr_idx                <= wr_idx + 3'd1;
              m_axi_control_AWADDR  <= wr_addr(wr_idx + 3'd1);
              m_axi_control_WDATA   <= wr_data(wr_idx + 3'd1, param_q, print_q);
              m_axi_control_AWVALID <= 1'b1;
              m_axi_control_WVALID  <= 1'b1;
              state                 <= S_WRITE;
            end
          end
        end

        S_POLL_WAIT: begin
          if (timed_out) begin
            rsp_status <= 2'b10;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (gap_cnt == GAP_LAST) begin
            m_axi_control_ARADDR  <= '0;
            m_axi_control_ARVALID <= 1'b1;
            state                 <= S_RD_ADDR;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        S_RD_ADDR: begin
          if (m_axi_control_ARREADY) begin
            m_axi_control_ARVALID <= 1'b0;
            m_axi_control_RREADY  <= 1'b1;
            state                 <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (m_axi_control_RVALID) begin
            m_axi_control_RREADY <= 1'b0;
            if (rsp_polls != 16'hFFFF) rsp_polls <= rsp_polls + 16'd1;
            // A read in flight at timeout still finishes; its error/done outranks the timeout
            if (m_axi_control_RRESP != 2'b00) begin
              rsp_status <= 2'b01;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else if (m_axi_control_RDATA[1]) begin
              rsp_status <= 2'b00;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else if (timed_out) begin
              rsp_status <= 2'b10;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else begin
              gap_cnt <= '0;
              state   <= S_POLL_WAIT;
            end
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sda_host_kernel_driver.sv
// tb/tb_sda_host_kernel_driver.sv - randomized self-checking bench for sda_host_kernel_driver
module tb_sda_host_kernel_driver;

  localparam int AW  = 6;
  localparam int GAP = 8;
  localparam int TO  = 100;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          cmd_valid, cmd_ready;
  logic [63:0]   cmd_param_base, cmd_print_base;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_status;
  logic [15:0]   rsp_polls;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, busy;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 ap_clk = ~ap_clk;

  sda_host_kernel_driver #(.AXI_SLAVE_ADDR_WIDTH(AW), .POLL_GAP(GAP), .TIMEOUT(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_param_base(cmd_param_base), .cmd_print_base(cmd_print_base),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_polls(rsp_polls),
    .m_axi_control_AWADDR(awaddr), .m_axi_control_AWVALID(awvalid), .m_axi_control_AWREADY(awready),
    .m_axi_control_WDATA(wdata), .m_axi_control_WSTRB(wstrb), .m_axi_control_WVALID(wvalid),
    .m_axi_control_WREADY(wready),
    .m_axi_control_BRESP(bresp), .m_axi_control_BVALID(bvalid), .m_axi_control_BREADY(bready),
    .m_axi_control_ARADDR(araddr), .m_axi_control_ARVALID(arvalid), .m_axi_control_ARREADY(arready),
    .m_axi_control_RDATA(rdata), .m_axi_control_RRESP(rresp), .m_axi_control_RVALID(rvalid),
    .m_axi_control_RREADY(rready),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Slave scenario: per-write ready delays, response delays, injected errors
  int aw_dly[5], w_dly[5];
  int b_dly, ar_dly, r_dly;
  int err_w;    // write index answered with SLVERR, 5 = none
  int done_at;  // 1-based read that reports ap_done, 0 = never
  int rerr_at;  // 1-based read answered with SLVERR, 0 = never

  // Slave bookkeeping
  logic [AW-1:0] aw_q[$];
  logic [31:0]   w_q[$];
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int aw_n, w_n, bw_n, rd_issued, rd_done;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit r_pend;
  int drops, strb_bad, ar_bad;
  bit p_awv, p_wv, p_arv, p_bready, p_rready;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [31:0]   p_wdata;
  logic [3:0]    p_wstrb;
  int  pc, rsp_pc;
  bit  pc_on;

  task automatic slave_clear();
    aw_q.delete(); w_q.delete(); log_addr.delete(); log_data.delete();
    aw_n = 0; w_n = 0; bw_n = 0; rd_issued = 0; rd_done = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; r_pend = 0;
    drops = 0; strb_bad = 0; ar_bad = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
    pc = 0; pc_on = 0; rsp_pc = -1;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
  endtask

  // One slave cycle, run just after each rising edge: retire what the edge
  // accepted, then set up the ready/valid levels for the next edge.
  task automatic slave_step();
    if (!ap_rst_n) begin
      slave_clear();
      return;
    end
    if (p_awv) begin
      if (awready) begin aw_q.push_back(p_awaddr); aw_n++; awready = 0; aw_cnt = 0; end
      else if (!awvalid || awaddr != p_awaddr) drops++;
    end
    if (p_wv) begin
      if (wready) begin
        w_q.push_back(p_wdata); w_n++; wready = 0; w_cnt = 0;
        if (p_wstrb != 4'hF) strb_bad++;
      end else if (!wvalid || wdata != p_wdata || wstrb != p_wstrb) drops++;
    end
    if (bvalid && p_bready) begin
      log_addr.push_back(aw_q.pop_front());
      log_data.push_back(w_q.pop_front());
      if (bw_n == 4 && bresp == 2'b00) begin pc_on = 1; pc = -1; end
      bw_n++; bvalid = 0; bresp = 0;
    end
    if (p_arv) begin
      if (arready) begin
        arready = 0; ar_cnt = 0; rd_issued++; r_pend = 1; r_cnt = 0;
        if (p_araddr != '0) ar_bad++;
      end else if (!arvalid || araddr != p_araddr) drops++;
    end
    if (rvalid && p_rready) begin rvalid = 0; rresp = 0; rdata = 0; rd_done++; end
    if (pc_on) begin
      pc++;
      if (rsp_valid) begin rsp_pc = pc; pc_on = 0; end
    end

    p_awv = awvalid; p_awaddr = awaddr; p_wv = wvalid; p_wdata = wdata; p_wstrb = wstrb;
    p_arv = arvalid; p_araddr = araddr; p_bready = bready; p_rready = rready;

    if (awvalid && !awready) begin
      if (aw_cnt >= aw_dly[aw_n > 4 ? 4 : aw_n]) awready = 1; else aw_cnt++;
    end
    if (wvalid && !wready) begin
      if (w_cnt >= w_dly[w_n > 4 ? 4 : w_n]) wready = 1; else w_cnt++;
    end
    if (!bvalid && aw_q.size() > 0 && w_q.size() > 0) begin
      if (b_cnt >= b_dly) begin
        bvalid = 1; b_cnt = 0;
        bresp = (bw_n == err_w) ? 2'b10 : 2'b00;
      end else b_cnt++;
    end
    if (arvalid && !arready) begin
      if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++;
    end
    if (r_pend && !rvalid) begin
      if (r_cnt >= r_dly) begin
        rvalid = 1; r_pend = 0;
        rresp  = (rd_issued == rerr_at) ? 2'b10 : 2'b00;
        rdata  = ($urandom() & ~32'h2) | ((rd_issued == done_at) ? 32'h2 : 32'h0);
      end else r_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
    slave_step();
  endtask

  task automatic set_scn(input int ew, input int da, input int re);
    err_w = ew; done_at = da; rerr_at = re;
    for (int i = 0; i < 5; i++) begin
      aw_dly[i] = $urandom_range(0, 3);
      w_dly[i]  = $urandom_range(0, 3);
    end
    b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
  endtask

  function automatic logic [95:0] all_outs();
    return {cmd_ready, rsp_valid, rsp_status, rsp_polls, awaddr, awvalid, wdata, wstrb,
            wvalid, bready, araddr, arvalid, rready, busy};
  endfunction

  task automatic launch(input string name, input logic [63:0] prm, input logic [63:0] prt);
    slave_clear();
    check({name, "/idle"}, {cmd_ready, busy, rsp_valid}, 3'b100);
    cmd_valid = 1; cmd_param_base = prm; cmd_print_base = prt;
    tick();
    cmd_valid = 0;
    cmd_param_base = {$urandom(), $urandom()};
    cmd_print_base = {$urandom(), $urandom()};
    check({name, "/accept"}, {cmd_ready, busy}, 2'b01);
  endtask

  task automatic run_cmd(input string name, input logic [63:0] prm, input logic [63:0] prt,
                         input int hold);
    int wait_cyc, unstable, nexp, ep, first;
    logic [1:0]    st, es;
    logic [15:0]   pl;
    logic [AW-1:0] ea[5];
    logic [31:0]   ed[5];

    launch(name, prm, prt);
    wait_cyc = 0;
    while (!rsp_valid && wait_cyc < 3000) begin tick(); wait_cyc++; end
    check({name, "/rsp_seen"}, rsp_valid, 1'b1);
    st = rsp_status; pl = rsp_polls; unstable = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!rsp_valid || rsp_status != st || rsp_polls != pl || cmd_ready || !busy) unstable++;
    end
    if (hold > 0) check({name, "/hold_stable"}, unstable, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check({name, "/after_rsp"}, {rsp_valid, busy, cmd_ready}, 3'b001);

    // Reference: the write list truncated at a write error; status from the
    // first read that is an error or done, otherwise a timeout.
    ea[0] = 'h10; ea[1] = 'h14; ea[2] = 'h18; ea[3] = 'h1C; ea[4] = 'h00;
    ed[0] = prm[31:0]; ed[1] = prm[63:32]; ed[2] = prt[31:0]; ed[3] = prt[63:32]; ed[4] = 32'h1;
    if (err_w < 5) begin
      nexp = err_w + 1; es = 2'b01; ep = 0;
    end else if (done_at == 0 && rerr_at == 0) begin
      nexp = 5; es = 2'b10; ep = rd_done;
    end else begin
      nexp  = 5;
      first = (rerr_at != 0 && (done_at == 0 || rerr_at <= done_at)) ? rerr_at : done_at;
      es    = (first == rerr_at) ? 2'b01 : 2'b00;
      ep    = first;
    end
    check({name, "/status"}, st, es);
    check({name, "/polls"}, pl, 16'(ep));
    check({name, "/n_writes"}, log_addr.size(), nexp);
    for (int i = 0; i < nexp && i < log_addr.size(); i++)
      check($sformatf("%s/write%0d", name, i), {log_addr[i], log_data[i]}, {ea[i], ed[i]});
    check({name, "/reads_done"}, rd_done, rd_issued);
    check({name, "/protocol"}, {drops[15:0], strb_bad[15:0], ar_bad[15:0]}, 48'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc, kind;
    ap_rst_n = 0; cmd_valid = 0; rsp_ready = 0;
    cmd_param_base = '0; cmd_print_base = '0;
    set_scn(5, 1, 0);
    slave_clear();
    repeat (3) tick();
    check("reset_outs", all_outs(), '0);
    #2 ap_rst_n = 1;
    #1 check("cmd_ready_before_edge", cmd_ready, 1'b0);
    tick();
    check("cmd_ready_first_edge", cmd_ready, 1'b1);

    // Nominal launch, done on third read
    set_scn(5, 3, 0);
    run_cmd("nominal", 64'h0000_0001_8000_0000, 64'h0000_0002_0000_0040, 0);

    // AW/W skew: AW first by 3, W first, same cycle
    set_scn(5, 1, 0);
    aw_dly[0] = 0; w_dly[0] = 3;
    aw_dly[1] = 2; w_dly[1] = 0;
    aw_dly[2] = 1; w_dly[2] = 1;
    run_cmd("skew", {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0);

    // SLVERR on the 0x14 write
    set_scn(1, 1, 0);
    run_cmd("bresp_err", {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0);

    // Never done: poll-phase timeout
    set_scn(5, 0, 0);
    run_cmd("timeout", {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0);
    check("timeout/not_early", rsp_pc > TO, 1'b1);
    check("timeout/not_late", rsp_pc <= TO + 10, 1'b1);

    // Response back-pressure
    set_scn(5, 2, 0);
    run_cmd("hold20", {$urandom(), $urandom()}, {$urandom(), $urandom()}, 20);

    // Randomized mix
    for (int k = 0; k < 10; k++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       set_scn(5, $urandom_range(1, 4), 0);
        1:       set_scn(5, $urandom_range(0, 4), $urandom_range(1, 3));
        default: set_scn($urandom_range(0, 4), 1, 0);
      endcase
      run_cmd($sformatf("rand%0d", k), {$urandom(), $urandom()}, {$urandom(), $urandom()},
              $urandom_range(0, 3));
    end

    // Reset while a status read is outstanding
    set_scn(5, 3, 0);
    r_dly = 3;
    launch("rst_mid", {$urandom(), $urandom()}, {$urandom(), $urandom()});
    wait_cyc = 0;
    while (!rready && wait_cyc < 500) begin tick(); wait_cyc++; end
    check("rst_mid/reached_rd_data", rready, 1'b1);
    #2 ap_rst_n = 0;
    #1 check("rst_mid/outs_immediate", all_outs(), '0);
    tick();
    tick();
    check("rst_mid/outs_held", all_outs(), '0);
    #2 ap_rst_n = 1;
    #1 check("rst_mid/cmd_ready_low", cmd_ready, 1'b0);
    tick();
    check("rst_mid/cmd_ready_high", cmd_ready, 1'b1);
    set_scn(5, 2, 0);
    run_cmd("after_rst", {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
